// File: rtl/ds_function.sv
// DS1302 3-wire engine: one single-byte write or read on CE/SCLK/IO, LSB first.
// Define DS_IO_SYNC_EN to put a 2-flop synchronizer on ds_io_in (sample point 2 cycles later).
module ds_function #(
  parameter int HALF_PERIOD = 25,
  parameter int CE_SETUP    = 200,
  parameter int CE_HOLD     = 50,
  parameter int CE_RECOVER  = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] func_start,
  input  logic [7:0] register_addr,
  input  logic [7:0] write_data,
  output logic       func_done,
  output logic [7:0] read_data,
  output logic       ds_ce,
  output logic       ds_sclk,
  output logic       ds_io_out,
  output logic       ds_io_oe,
  input  logic       ds_io_in
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETUP   = 3'd1;
  localparam logic [2:0] S_SHIFT   = 3'd2;
  localparam logic [2:0] S_HOLD    = 3'd3;
  localparam logic [2:0] S_FINISH  = 3'd4;
  localparam logic [2:0] S_RECOVER = 3'd5;

`ifdef DS_IO_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  localparam int MAX_A   = (CE_SETUP > CE_HOLD) ? CE_SETUP : CE_HOLD;
  localparam int MAX_B   = (CE_RECOVER > HALF_PERIOD + SYNC_LAT) ? CE_RECOVER : HALF_PERIOD + SYNC_LAT;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] SETUP_LAST  = CW'(CE_SETUP - 1);
  localparam logic [CW-1:0] HP_LAST     = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] SLOT15_LAST = CW'(HALF_PERIOD - 1 + SYNC_LAT);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(CE_HOLD - 1);
  localparam logic [CW-1:0] REC_LAST    = CW'(CE_RECOVER - 1);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic          phase_q, phase_d;   // 0 = SCLK low phase, 1 = high phase
  logic          rd_q, rd_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic [7:0]    shadow_q;
  logic [7:0]    read_data_q, read_data_d;
  logic          done_q, ce_q, sclk_q, io_out_q, oe_q;
  logic          ce_d, sclk_d, io_out_d, oe_d;
  logic          io_smp, sample_en, accept, last_rd_slot;

  assign accept       = (func_start == 2'b10) || (func_start == 2'b01);
  assign last_rd_slot = rd_q && (bit_q == 4'd15);

`ifdef DS_IO_SYNC_EN
  logic [1:0] io_sync_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) io_sync_q <= 2'b00;
    else     io_sync_q <= {io_sync_q[0], ds_io_in};
  end
  assign io_smp    = io_sync_q[1];
  // Slots 8..14 sample early in the high phase; slot 15 stretches its low phase instead.
  assign sample_en = (state_q == S_SHIFT) && rd_q && bit_q[3] &&
                     ((last_rd_slot && !phase_q && cnt_q == SLOT15_LAST) ||
                      (!last_rd_slot && phase_q && cnt_q == CW'(1)));
`else
  assign io_smp    = ds_io_in;
  assign sample_en = (state_q == S_SHIFT) && rd_q && bit_q[3] && !phase_q && (cnt_q == HP_LAST);
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_SETUP;
          cnt_d   = '0;
          bit_d   = 4'd0;
          phase_d = 1'b0;
          rd_d    = (func_start == 2'b01);
          addr_d  = register_addr;
          data_d  = write_data;
        end
      end
      S_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
          bit_d   = 4'd0;
          phase_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SHIFT: begin
        if (!phase_q) begin
          if (last_rd_slot && cnt_q == SLOT15_LAST) begin
            state_d = S_HOLD;   // read slot 15 has no high phase
            cnt_d   = '0;
          end else if (!last_rd_slot && cnt_q == HP_LAST) begin
            phase_d = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (cnt_q == HP_LAST) begin
          cnt_d = '0;
          if (bit_q == 4'd15) begin
            state_d = S_HOLD;
          end else begin
            bit_d   = bit_q + 4'd1;
            phase_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = S_FINISH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_FINISH: begin
        state_d = S_RECOVER;
        cnt_d   = '0;
      end
      S_RECOVER: begin
        if (cnt_q == REC_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Pin values are decoded from the next state and registered, so the pins never glitch.
  always_comb begin
    ce_d        = (state_d == S_SETUP) || (state_d == S_SHIFT) || (state_d == S_HOLD);
    sclk_d      = (state_d == S_SHIFT) && phase_d;
    oe_d        = (state_d == S_SETUP) || ((state_d == S_SHIFT) && (!rd_d || !bit_d[3]));
    io_out_d    = 1'b0;
    read_data_d = read_data_q;
    if (state_d == S_SETUP) begin
      io_out_d = addr_d[0];
    end else if (state_d == S_SHIFT) begin
      if (!bit_d[3])  io_out_d = addr_d[bit_d[2:0]];
      else if (!rd_d) io_out_d = data_d[bit_d[2:0]];
    end
    if (state_d == S_FINISH && rd_q) read_data_d = shadow_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= 4'd0;
      phase_q     <= 1'b0;
      rd_q        <= 1'b0;
      addr_q      <= 8'h00;
      data_q      <= 8'h00;
      shadow_q    <= 8'h00;
      read_data_q <= 8'h00;
      done_q      <= 1'b0;
      ce_q        <= 1'b0;
      sclk_q      <= 1'b0;
      io_out_q    <= 1'b0;
      oe_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      phase_q     <= phase_d;
      rd_q        <= rd_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      read_data_q <= read_data_d;
      done_q      <= (state_d == S_FINISH);
      ce_q        <= ce_d;
      sclk_q      <= sclk_d;
      io_out_q    <= io_out_d;
      oe_q        <= oe_d;
      if (sample_en) shadow_q[bit_q[2:0]] <= io_smp;
    end
  end

  assign func_done = done_q;
  assign read_data = read_data_q;
  assign ds_ce     = ce_q;
  assign ds_sclk   = sclk_q;
  assign ds_io_out = io_out_q;
  assign ds_io_oe  = oe_q;

endmodule

// File: tb/tb_ds_function.sv
// Scoreboard bench for ds_function: requester pushes expected transactions, a monitor
// reconstructs each CE window from the pins and compares at func_done.
module tb_ds_function;

  localparam int WR_CE = 1050;   // 200 + 32*25 + 50
`ifdef DS_IO_SYNC_EN
  localparam int RD_CE = 1027;   // 200 + 31*25 + 50 + 2
`else
  localparam int RD_CE = 1025;   // 200 + 31*25 + 50
`endif
  localparam int GAP_CE = 202;   // FINISH + 200 RECOVER + first IDLE cycle

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] func_start = 2'b00;
  logic [7:0] register_addr = 8'h00;
  logic [7:0] write_data = 8'h00;
  logic       func_done;
  logic [7:0] read_data;
  logic       ds_ce, ds_sclk, ds_io_out, ds_io_oe;
  logic       ds_io_in;

  ds_function dut (
    .clk(clk), .rst(rst), .func_start(func_start), .register_addr(register_addr),
    .write_data(write_data), .func_done(func_done), .read_data(read_data),
    .ds_ce(ds_ce), .ds_sclk(ds_sclk), .ds_io_out(ds_io_out), .ds_io_oe(ds_io_oe),
    .ds_io_in(ds_io_in)
  );

  always #10 clk = ~clk;

  typedef struct {
    bit         rd;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] exp_rd;
    int         exp_gap;
  } txn_t;

  txn_t       sb_q[$];
  int         errors = 0;
  int         checks = 0;
  logic [7:0] last_rd = 8'h00;
  logic [7:0] slave_byte = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slave: after each SCLK fall from the 8th, present the next bit of slave_byte.
  int   sl_falls;
  logic sl_prev_sclk;
  always @(negedge clk) begin
    if (!ds_ce) begin
      sl_falls     = 0;
      ds_io_in     = 1'b1;
      sl_prev_sclk = 1'b0;
    end else begin
      if (sl_prev_sclk && !ds_sclk) begin
        sl_falls++;
        if (sl_falls >= 8 && sl_falls <= 15) ds_io_in = slave_byte[3'(sl_falls - 8)];
      end
      sl_prev_sclk = ds_sclk;
    end
  end

  // Monitor
  int          ce_cnt, low_cnt, gap_last, rises, falls, oe_late, done_cnt = 0;
  logic [15:0] cap, oe_r;
  logic        prev_ce, prev_sclk, prev_done;
  txn_t        mt;
  always @(negedge clk) begin
    if (rst) begin
      ce_cnt = 0; low_cnt = 0; gap_last = 0; rises = 0; falls = 0; oe_late = 0;
      cap = '0; oe_r = '0; prev_ce = 0; prev_sclk = 0; prev_done = 0;
    end else begin
      if (ds_ce && !prev_ce) begin
        gap_last = low_cnt;
        low_cnt = 0; ce_cnt = 0; rises = 0; falls = 0; oe_late = 0; cap = '0; oe_r = '0;
      end
      if (ds_ce) ce_cnt++;
      else       low_cnt++;
      if (ds_sclk && !prev_sclk) begin
        if (rises < 16) begin
          cap[rises]  = ds_io_out;
          oe_r[rises] = ds_io_oe;
        end
        rises++;
      end
      if (!ds_sclk && prev_sclk) falls++;
      if (ds_ce && falls >= 8 && ds_io_oe) oe_late++;
      if (prev_done) check("done_width", func_done, 0);
      if (func_done) begin
        done_cnt++;
        if (sb_q.size() == 0) begin
          check("unexpected_done", func_done, 0);
        end else begin
          mt = sb_q.pop_front();
          check("ce_high_cycles", ce_cnt, mt.rd ? RD_CE : WR_CE);
          check("sclk_rises", rises, mt.rd ? 15 : 16);
          check("io_stream", mt.rd ? {8'h00, cap[7:0]} : cap,
                mt.rd ? {8'h00, mt.addr} : {mt.data, mt.addr});
          check("oe_at_rises", oe_r, mt.rd ? 16'h00FF : 16'hFFFF);
          check("read_data", read_data, mt.exp_rd);
          check("ce_fall_with_done", {prev_ce, ds_ce}, 2'b10);
          if (mt.rd) check("oe_after_8th_fall", oe_late, 0);
          if (mt.exp_gap != 0) check("ce_low_gap", gap_last, mt.exp_gap);
        end
      end
      prev_ce   = ds_ce;
      prev_sclk = ds_sclk;
      prev_done = func_done;
    end
  end

  task automatic issue(input bit rd, input logic [7:0] a, input logic [7:0] d,
                       input logic [7:0] sb, input int gap);
    txn_t t;
    t.rd      = rd;
    t.addr    = a;
    t.data    = d;
    t.exp_rd  = rd ? sb : last_rd;
    t.exp_gap = gap;
    if (rd) last_rd = sb;
    sb_q.push_back(t);
    slave_byte    = sb;
    func_start    = rd ? 2'b01 : 2'b10;
    register_addr = a;
    write_data    = d;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (func_done) return;
    end
    check("done_timeout", func_done, 1);
  endtask

  task automatic release_req();
    @(posedge clk);
    #1 func_start = 2'b00;
  endtask

  bit         seq_rd   [8] = '{0, 0, 0, 0, 0, 1, 1, 1};
  logic [7:0] seq_addr [8] = '{8'h8E, 8'h84, 8'h82, 8'h80, 8'h8E, 8'h85, 8'h83, 8'h81};
  logic [7:0] seq_data [8] = '{8'h00, 8'h00, 8'h21, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00};
  logic [7:0] seq_slv  [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h12, 8'h59, 8'hA5};

  initial begin
    int bad;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ce", ds_ce, 0);
    check("rst_sclk", ds_sclk, 0);
    check("rst_oe", ds_io_oe, 0);
    check("rst_io_out", ds_io_out, 0);
    check("rst_done", func_done, 0);
    check("rst_read_data", read_data, 8'h00);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Write 8E/00; inputs scrambled mid-transaction must not matter.
    issue(0, 8'h8E, 8'h00, 8'h00, 0);
    repeat (100) @(posedge clk);
    #1 register_addr = 8'hFF;
    write_data = 8'hFF;
    wait_done();
    release_req();

    // Read 85 requested during RECOVER: accepted on the first IDLE cycle.
    repeat (10) @(posedge clk);
    #1 issue(1, 8'h85, 8'h00, 8'h08, GAP_CE);
    wait_done();
    release_req();

    // Illegal request held 500 cycles.
    func_start = 2'b11;
    register_addr = 8'h8E;
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (ds_ce || func_done) bad++;
    end
    check("illegal_ignored", bad, 0);
    @(posedge clk);
    #1 func_start = 2'b10;
    register_addr = 8'hA0;
    write_data    = 8'h55;

    // Reset in the high phase of slot 5 (addr bit 5 = 1, so IO is high there).
    repeat (481) @(posedge clk);
    #1;
    check("pre_rst_sclk", ds_sclk, 1);
    check("pre_rst_io", ds_io_out, 1);
    rst = 1'b1;
    func_start = 2'b00;
    last_rd = 8'h00;
    #1;
    check("mid_rst_ce", ds_ce, 0);
    check("mid_rst_sclk", ds_sclk, 0);
    check("mid_rst_oe", ds_io_oe, 0);
    check("mid_rst_io_out", ds_io_out, 0);
    check("mid_rst_read_data", read_data, 8'h00);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (300) @(posedge clk);
    #1 issue(1, 8'h81, 8'h00, 8'h21, 0);
    wait_done();
    release_req();

    // Back-to-back sequencer run.
    for (int k = 0; k < 8; k++) begin
      #1 issue(seq_rd[k], seq_addr[k], seq_data[k], seq_slv[k], GAP_CE);
      wait_done();
      release_req();
    end

    repeat (20) @(posedge clk);
    check("all_responses_seen", sb_q.size(), 0);
    check("done_count", done_cnt, 11);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule
